// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and write-back.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   ws_allowin       write-back can accept an instruction this cycle
//   ms_allowin       this stage can accept an instruction this cycle
//   es_to_ms_valid   execute stage offers a valid instruction
//   es_to_ms_bus     {res_from_mem, gr_we, dest[4:0], alu_result[31:0], pc[31:0]}
//   data_sram_rdata  synchronous SRAM read data, valid only in the first MEM cycle
//   ms_to_ws_valid   valid instruction offered to write-back
//   ms_to_ws_bus     {gr_we, dest[4:0], final_result[31:0], pc[31:0]}
//   ms_fwd_bus       {fwd_valid, fwd_is_load, dest[4:0], final_result[31:0]}
//                    (only when MEM_FWD_EN is defined)
module mem_stage #(
    parameter int RDATA_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ws_allowin,
    output logic               ms_allowin,
    input  logic               es_to_ms_valid,
    input  logic [70:0]        es_to_ms_bus,
    input  logic [RDATA_W-1:0] data_sram_rdata,
    output logic               ms_to_ws_valid,
    output logic [69:0]        ms_to_ws_bus
`ifdef MEM_FWD_EN
    ,
    output logic [38:0]        ms_fwd_bus
`endif
);
    typedef enum logic [1:0] {IDLE, FRESH, HELD} state_t;

    state_t             state, state_n;
    logic               ms_valid;
    logic               ms_ready_go;
    logic               accept;
    logic               buf_we;
    logic [70:0]        bus_r;
    logic [RDATA_W-1:0] rdata_buf;
    logic [RDATA_W-1:0] ld_data;
    logic [RDATA_W-1:0] final_result;
    logic               res_from_mem;
    logic               gr_we;
    logic [4:0]         dest;
    logic [31:0]        alu_result;
    logic [31:0]        pc;

    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign accept         = es_to_ms_valid && ms_allowin;

    assign {res_from_mem, gr_we, dest, alu_result, pc} = bus_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid  <= 1'b0;
            bus_r     <= '0;
            state     <= IDLE;
            rdata_buf <= '0;
        end else begin
            if (ms_allowin) ms_valid <= es_to_ms_valid;
            if (accept) bus_r <= es_to_ms_bus;
            if (buf_we) rdata_buf <= data_sram_rdata;
            state <= state_n;
        end
    end

    // The SRAM output is only valid in the first MEM cycle, so a stall
    // out of FRESH must capture it before it disappears.
    always_comb begin
        state_n = state;
        buf_we  = 1'b0;
        if (accept)
            state_n = FRESH;
        else if (state == FRESH && ms_valid && !ws_allowin) begin
            state_n = HELD;
            buf_we  = 1'b1;
        end else if (state != IDLE && ws_allowin)
            state_n = IDLE;
    end

    assign ld_data      = (state == HELD) ? rdata_buf : data_sram_rdata;
    assign final_result = res_from_mem ? ld_data : alu_result;
    assign ms_to_ws_bus = {gr_we, dest, final_result, pc};

`ifdef MEM_FWD_EN
    assign ms_fwd_bus = {ms_valid && gr_we && (dest != 5'd0), ms_valid && res_from_mem,
                         dest, final_result};
`endif
endmodule
